// File: rtl/mouse_bus_bridge.sv
// Mouse packet FIFO bridged onto the 8-bit processor bus through a seven-register
// window, with sticky overflow tracking, pop/flush control and an acked interrupt.
module mouse_bus_bridge #(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         FIFO_DEPTH = 4,
    parameter int         PTR_W      = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PKT_VALID,
    input  logic [3:0] PKT_STATUS,
    input  logic [7:0] PKT_X,
    input  logic [7:0] PKT_Y,
    input  logic [7:0] PKT_Z,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       IRQ_RAISE,
    input  logic       IRQ_ACK,
    output logic [3:0] FIFO_LEVEL
);

    localparam int                 CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [27:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [27:0]      head;

    logic       ovf;
    logic       irq_en;
    logic       drive_en;
    logic [7:0] out_reg;
    logic [7:0] rd_sel;
    logic [7:0] offset;
    logic [3:0] level;

    logic in_win, wr_hit, ctrl_wr, cfg_wr;
    logic full, empty, flush, pop, clr_ovf, push, drop;
    logic unused_wdata;

    // Unsigned offset: addresses below BASE_ADDR wrap high and fall outside the window.
    assign offset  = BUS_ADDR - BASE_ADDR;
    assign in_win  = offset < 8'd7;
    assign wr_hit  = BUS_WE && in_win;
    assign ctrl_wr = wr_hit && (offset == 8'd5);
    assign cfg_wr  = wr_hit && (offset == 8'd6);

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);

    // Flush outranks pop and swallows a same-cycle packet without flagging overflow.
    assign flush   = ctrl_wr && BUS_DATA[2];
    assign pop     = ctrl_wr && BUS_DATA[0] && !flush && !empty;
    assign clr_ovf = ctrl_wr && BUS_DATA[1];
    assign push    = PKT_VALID && !flush && (!full || pop);
    assign drop    = PKT_VALID && !flush && full && !pop;

    assign unused_wdata = ^BUS_DATA[7:3];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {PKT_STATUS, PKT_X, PKT_Y, PKT_Z};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf       <= 1'b0;
            irq_en    <= 1'b1;
            IRQ_RAISE <= 1'b0;
        end else begin
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;

            if (cfg_wr) irq_en <= BUS_DATA[0];

            // Masking only gates new requests; a pending one waits for the ack.
            if (push && irq_en) IRQ_RAISE <= 1'b1;
            else if (IRQ_ACK)   IRQ_RAISE <= 1'b0;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        level = '0;
        level[PTR_W:0] = count;
    end

    assign FIFO_LEVEL = level;

    always_comb begin
        rd_sel = '0;
        case (offset)
            8'd0:    rd_sel = empty ? 8'h00 : {4'h0, head[27:24]};
            8'd1:    rd_sel = empty ? 8'h00 : head[23:16];
            8'd2:    rd_sel = empty ? 8'h00 : head[15:8];
            8'd3:    rd_sel = empty ? 8'h00 : head[7:0];
            8'd4:    rd_sel = {ovf, 3'b000, level};
            8'd6:    rd_sel = {7'h00, irq_en};
            default: rd_sel = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            drive_en <= 1'b0;
            out_reg  <= '0;
        end else begin
            drive_en <= !BUS_WE && in_win;
            out_reg  <= rd_sel;
        end
    end

    assign BUS_DATA = drive_en ? out_reg : 8'bz;

endmodule

// File: tb/tb_mouse_bus_bridge.sv
// Randomized bench for mouse_bus_bridge: a queue-based packet model predicts every
// bus read, FIFO level and interrupt state, plus a short directed walk of key cases.
module tb_mouse_bus_bridge;

    localparam logic [7:0] BASE  = 8'hA0;
    localparam int         DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       PKT_VALID = 1'b0;
    logic [3:0] PKT_STATUS = '0;
    logic [7:0] PKT_X = '0, PKT_Y = '0, PKT_Z = '0;
    logic [7:0] BUS_ADDR = 8'h50;
    logic       BUS_WE = 1'b0;
    logic       IRQ_ACK = 1'b0;
    logic       IRQ_RAISE;
    logic [3:0] FIFO_LEVEL;
    wire  [7:0] BUS_DATA;

    logic       tb_oe = 1'b0;
    logic [7:0] tb_wd = '0;

    assign BUS_DATA = tb_oe ? tb_wd : 8'bz;
    pullup (BUS_DATA);

    mouse_bus_bridge #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .PKT_STATUS(PKT_STATUS),
        .PKT_X(PKT_X), .PKT_Y(PKT_Y), .PKT_Z(PKT_Z), .BUS_DATA(BUS_DATA),
        .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .IRQ_RAISE(IRQ_RAISE),
        .IRQ_ACK(IRQ_ACK), .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h", tag, got, exp);
        end
    endtask

    // Reference state: packets as a queue, oldest at index 0.
    logic [27:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_en  = 1'b1;
    bit          m_irq = 1'b0;
    bit          m_drv = 1'b0;
    logic [7:0]  last_bus;

    function automatic logic [7:0] model_reg(input logic [7:0] off);
        logic [27:0] h;
        h = (q.size() > 0) ? q[0] : 28'h0;
        case (off)
            8'd0:    return {4'h0, h[27:24]};
            8'd1:    return h[23:16];
            8'd2:    return h[15:8];
            8'd3:    return h[7:0];
            8'd4:    return {m_ovf, 3'b000, 4'(q.size())};
            8'd6:    return {7'h00, m_en};
            default: return 8'h00;
        endcase
    endfunction

    task automatic apply(input bit rst, input bit pv, input logic [27:0] pkt,
                         input logic [7:0] addr, input bit we, input logic [7:0] wd,
                         input bit ack);
        logic [7:0] off, exp_bus;
        bit drv, wr, flush, popr, clr, acc, ovfl;
        RESET = rst; PKT_VALID = pv;
        {PKT_STATUS, PKT_X, PKT_Y, PKT_Z} = pkt;
        BUS_ADDR = addr; BUS_WE = we; tb_oe = we; tb_wd = wd; IRQ_ACK = ack;

        off     = addr - BASE;
        drv     = !rst && !we && (off < 8'd7);
        exp_bus = we ? wd : (drv ? model_reg(off) : 8'hFF);

        if (rst) begin
            q.delete(); m_ovf = 1'b0; m_en = 1'b1; m_irq = 1'b0;
        end else begin
            wr    = we && (off < 8'd7);
            flush = wr && off == 8'd5 && wd[2];
            popr  = wr && off == 8'd5 && wd[0];
            clr   = wr && off == 8'd5 && wd[1];
            acc = 1'b0; ovfl = 1'b0;
            if (flush) q.delete();
            else begin
                if (popr && q.size() > 0) void'(q.pop_front());
                if (pv) begin
                    if (q.size() < DEPTH) begin q.push_back(pkt); acc = 1'b1; end
                    else ovfl = 1'b1;
                end
            end
            if (clr)  m_ovf = 1'b0;
            if (ovfl) m_ovf = 1'b1;
            if (acc && m_en) m_irq = 1'b1;
            else if (ack)    m_irq = 1'b0;
            if (wr && off == 8'd6) m_en = wd[0];
        end

        @(posedge CLK); #1;
        m_drv    = drv;
        last_bus = BUS_DATA;
        chk($sformatf("bus@%02h", addr), BUS_DATA, exp_bus);
        chk("level", {4'h0, FIFO_LEVEL}, 8'(q.size()));
        chk("irq", {7'h00, IRQ_RAISE}, {7'h00, m_irq});
    endtask

    // A write right after a read would fight the bridge's driver, so park the bus first.
    task automatic step(input bit rst, input bit pv, input logic [27:0] pkt,
                        input logic [7:0] addr, input bit we, input logic [7:0] wd,
                        input bit ack);
        if (we && m_drv) apply(1'b0, 1'b0, 28'h0, 8'h50, 1'b0, 8'h00, 1'b0);
        apply(rst, pv, pkt, addr, we, wd, ack);
    endtask

    task automatic idle();                      step(0, 0, 28'h0, 8'h50, 0, 8'h00, 0); endtask
    task automatic rd(input logic [7:0] o);     step(0, 0, 28'h0, BASE + o, 0, 8'h00, 0); endtask
    task automatic wr(input logic [7:0] o, input logic [7:0] d); step(0, 0, 28'h0, BASE + o, 1, d, 0); endtask
    task automatic push(input logic [27:0] p);  step(0, 1, p, 8'h50, 0, 8'h00, 0); endtask
    task automatic ack();                       step(0, 0, 28'h0, 8'h50, 0, 8'h00, 1); endtask
    task automatic rst();                       step(1, 0, 28'h0, 8'h50, 0, 8'h00, 0); endtask

    initial begin
        rst();
        rd(4); chk("rst_r4", last_bus, 8'h00);
        rd(6); chk("rst_r6", last_bus, 8'h01);
        idle(); chk("rst_z", last_bus, 8'hFF);

        push({4'hA, 8'h12, 8'h34, 8'hFE}); chk("irq_set", {7'h0, IRQ_RAISE}, 8'h01);
        rd(0); chk("r0", last_bus, 8'h0A);
        rd(1); chk("r1", last_bus, 8'h12);
        rd(2); chk("r2", last_bus, 8'h34);
        rd(3); chk("r3", last_bus, 8'hFE);
        rd(4); chk("r4", last_bus, 8'h01);
        ack(); chk("irq_ack", {7'h0, IRQ_RAISE}, 8'h00);
        wr(5, 8'h01);

        for (int i = 1; i <= 5; i++) push({4'h8, 8'(i), 8'h00, 8'h00});
        rd(4); chk("ovf_full", last_bus, 8'h84);
        for (int i = 1; i <= 4; i++) begin
            rd(1); chk("pop_order", last_bus, 8'(i));
            wr(5, 8'h01);
        end
        rd(1); chk("empty_r1", last_bus, 8'h00);

        wr(5, 8'h02);
        for (int i = 0; i < 4; i++) push({4'h8, 8'(8'h10 + i), 8'h00, 8'h00});
        step(0, 1, {4'h8, 8'h20, 8'h00, 8'h00}, BASE + 8'd5, 1, 8'h01, 0);
        rd(4); chk("push_pop_full", last_bus, 8'h04);
        for (int i = 0; i < 3; i++) wr(5, 8'h01);
        rd(1); chk("tail_pkt", last_bus, 8'h20);

        ack(); wr(6, 8'h00); wr(5, 8'h04);
        push(28'h1234567); chk("irq_masked", {7'h0, IRQ_RAISE}, 8'h00);
        rd(4); chk("mask_cnt", last_bus, 8'h01);
        wr(5, 8'h04); rd(4); chk("flush", last_bus, 8'h00);
        for (int i = 0; i < 5; i++) push(28'($urandom));
        wr(5, 8'h02); rd(4); chk("clr_ovf", last_bus, 8'h04);
        wr(6, 8'h01); wr(5, 8'h04);

        for (int i = 0; i < 3; i++) push(28'($urandom));
        chk("pre_rst_irq", {7'h0, IRQ_RAISE}, 8'h01);
        rst();
        chk("rst_lvl", {4'h0, FIFO_LEVEL}, 8'h00);
        rd(6); chk("rst_en", last_bus, 8'h01);

        for (int i = 0; i < 600; i++) begin
            int r;
            bit pv, ak;
            logic [27:0] p;
            r  = $urandom_range(0, 99);
            pv = 1'($urandom_range(0, 1));
            ak = ($urandom_range(0, 4) == 0);
            p  = 28'($urandom);
            if (r < 2)       step(1, pv, p, 8'h50, 0, 8'h00, ak);
            else if (r < 40) step(0, pv, p, BASE + 8'($urandom_range(0, 7)), 0, 8'h00, ak);
            else if (r < 55) step(0, pv, p, BASE + 8'd5, 1,
                                  {5'($urandom), 1'($urandom_range(0, 7) == 0), 2'($urandom)}, ak);
            else if (r < 60) step(0, pv, p, BASE + 8'd6, 1, 8'($urandom), ak);
            else if (r < 63) step(0, pv, p, BASE + 8'($urandom_range(0, 4)), 1, 8'($urandom), ak);
            else if (r < 68) step(0, pv, p, 8'($urandom), 1'($urandom), 8'($urandom), ak);
            else             step(0, pv, p, 8'h50, 0, 8'h00, ak);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
